// File: rtl/exu_alu_arb_if.sv
// Handshake and ALU-side signal bundle for exu_alu_arb.
// The slave modport is the arbiter; the master modport is the requester/ALU environment.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 4
`endif
`ifndef NO_FUNC
`define NO_FUNC 0
`endif
`ifndef ADD
`define ADD 1
`endif
`ifndef SUB
`define SUB 2
`endif
`ifndef XOR
`define XOR 3
`endif
`ifndef LESS_U
`define LESS_U 4
`endif

interface exu_alu_arb_if #(
   parameter int DATA_W = `ISA_WIDTH,
   parameter int FUNC_W = `ALU_FUNC_WIDTH
);
   logic              req_valid_0, req_valid_1;
   logic              req_ready_0, req_ready_1;
   logic [DATA_W-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
   logic [FUNC_W-1:0] req_func_0, req_func_1;
   logic              resp_valid_0, resp_valid_1;
   logic              resp_ready_0, resp_ready_1;
   logic [DATA_W-1:0] resp_result;
   logic [DATA_W-1:0] alu_a, alu_b;
   logic [FUNC_W-1:0] alu_func;
   logic [DATA_W-1:0] alu_result;
   logic              last_grant;

   modport slave (
      input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
      input  req_func_0, req_func_1, resp_ready_0, resp_ready_1, alu_result,
      output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_result,
      output alu_a, alu_b, alu_func, last_grant
   );

   modport master (
      output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
      output req_func_0, req_func_1, resp_ready_0, resp_ready_1, alu_result,
      input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_result,
      input  alu_a, alu_b, alu_func, last_grant
   );
endinterface

// File: rtl/exu_alu_arb.sv
// Two-requester arbiter sharing one combinational ALU, one operation in flight (IDLE/EXEC/RESP).
// Define EXU_ALU_ARB_RR_EN for round-robin on contention; otherwise requester 0 always wins.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 4
`endif
`ifndef NO_FUNC
`define NO_FUNC 0
`endif

module exu_alu_arb #(
   parameter int DATA_W = `ISA_WIDTH,
   parameter int FUNC_W = `ALU_FUNC_WIDTH
) (
   input logic           clk,
   input logic           rst,
   exu_alu_arb_if.slave  bus
);
   localparam logic [FUNC_W-1:0] NO_FUNC_C = FUNC_W'(`NO_FUNC);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state, state_nxt;
   logic              last_grant;
   logic              gnt, gnt_q, accept;
   logic [DATA_W-1:0] a_q, b_q, result_q;
   logic [FUNC_W-1:0] func_q;

   // Grant index is only meaningful in IDLE; a lone valid requester always wins.
   always_comb begin
      if (bus.req_valid_0 && bus.req_valid_1) begin
`ifdef EXU_ALU_ARB_RR_EN
         gnt = ~last_grant;
`else
         gnt = 1'b0;
`endif
      end else begin
         gnt = bus.req_valid_1;
      end
   end

   always_comb begin
      state_nxt        = state;
      accept           = 1'b0;
      bus.req_ready_0  = 1'b0;
      bus.req_ready_1  = 1'b0;
      bus.resp_valid_0 = 1'b0;
      bus.resp_valid_1 = 1'b0;
      bus.alu_a        = '0;
      bus.alu_b        = '0;
      bus.alu_func     = NO_FUNC_C;
      unique case (state)
         IDLE: begin
            bus.req_ready_0 = ~gnt;
            bus.req_ready_1 = gnt;
            accept          = gnt ? bus.req_valid_1 : bus.req_valid_0;
            if (accept) state_nxt = EXEC;
         end
         EXEC: begin
            bus.alu_a    = a_q;
            bus.alu_b    = b_q;
            bus.alu_func = func_q;
            state_nxt    = RESP;
         end
         RESP: begin
            bus.resp_valid_0 = ~gnt_q;
            bus.resp_valid_1 = gnt_q;
            if (gnt_q ? bus.resp_ready_1 : bus.resp_ready_0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt_q      <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         func_q     <= NO_FUNC_C;
         result_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            gnt_q      <= gnt;
            last_grant <= gnt;
            a_q        <= gnt ? bus.req_a_1    : bus.req_a_0;
            b_q        <= gnt ? bus.req_b_1    : bus.req_b_0;
            func_q     <= gnt ? bus.req_func_1 : bus.req_func_0;
         end
         if (state == EXEC) result_q <= bus.alu_result;
      end
   end

   assign bus.resp_result = result_q;
   assign bus.last_grant  = last_grant;
endmodule
